vpu_wb_writer: RTL and testbench

VPU_WB_WRITER -- requirements
Module: VPU_WB_WRITER

---
 rtl/vpu_wb_writer_pkg.sv | 15 +
 rtl/vpu_wb_writer_if.sv | 32 +++
 rtl/vpu_wb_writer.sv | 130 +++++++++++++
 tb/tb_vpu_wb_writer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vpu_wb_writer_pkg.sv
// Shared definitions for the VPU write-back writer.
//   VPU_OPERAND_ADDR_WIDTH : default width of a write-back operand address
//   VPU_DATA_WIDTH         : default width of one execute-stage result word
//   wb_state_e             : writer FSM states
package vpu_wb_writer_pkg;

    localparam int VPU_OPERAND_ADDR_WIDTH = 8;
    localparam int VPU_DATA_WIDTH         = 16;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_WRITE = 1'b1
    } wb_state_e;

endpackage

// File: rtl/vpu_wb_writer_if.sv
// Operand-buffer write channel (valid/ready).
//   wr_valid : write request, driven by the writer (master)
//   waddr    : operand address, driven by the writer
//   wdata    : operand data, driven by the writer
//   wr_ready : operand buffer accepts the write (slave)
interface vpu_wb_writer_if
    import vpu_wb_writer_pkg::*;
#(
    parameter int OPERAND_ADDR_WIDTH = VPU_OPERAND_ADDR_WIDTH,
    parameter int DATA_WIDTH         = VPU_DATA_WIDTH
);

    logic                          wr_valid;
    logic [OPERAND_ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0]         wdata;
    logic                          wr_ready;

    modport master (
        output wr_valid,
        output waddr,
        output wdata,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  waddr,
        input  wdata,
        output wr_ready
    );

endinterface

// File: rtl/vpu_wb_writer.sv
// VPU write-back writer: pairs the head of the external write-back address
// FIFO (show-ahead read side) with the next execute-stage result and issues
// one operand-buffer write per pair, sustaining one write per cycle.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   reset_cmd_i     : synchronous abort/clear (aborts pending write, clears count)
//   addr_empty_i    : address FIFO empty flag
//   addr_rdata_i    : address FIFO head
//   addr_rden_o     : address FIFO pop (always equal to result_ready_o)
//   result_valid_i  : execute result valid
//   result_i        : execute result data
//   result_ready_o  : execute result consumed this cycle
//   wb              : operand-buffer write channel (master side)
//   done_o          : one-cycle pulse per completed write
//   wb_cnt_o        : completed writes since last clear (wraps)
module vpu_wb_writer
    import vpu_wb_writer_pkg::*;
#(
    parameter int OPERAND_ADDR_WIDTH = VPU_OPERAND_ADDR_WIDTH,
    parameter int DATA_WIDTH         = VPU_DATA_WIDTH,
    parameter int CNT_WIDTH          = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          reset_cmd_i,
    input  logic                          addr_empty_i,
    input  logic [OPERAND_ADDR_WIDTH-1:0] addr_rdata_i,
    output logic                          addr_rden_o,
    input  logic                          result_valid_i,
    input  logic [DATA_WIDTH-1:0]         result_i,
    output logic                          result_ready_o,
    vpu_wb_writer_if.master               wb,
    output logic                          done_o,
    output logic [CNT_WIDTH-1:0]          wb_cnt_o
);

    wb_state_e                     state_r;
    logic                          wr_valid_r;
    logic [OPERAND_ADDR_WIDTH-1:0] waddr_r;
    logic [DATA_WIDTH-1:0]         wdata_r;
    logic                          done_r;
    logic [CNT_WIDTH-1:0]          wb_cnt_r;

    logic                          pair_avail_s;
    logic                          wr_fire_s;
    logic                          load_s;

    // Handshake decode: a new pair may load when idle or when the current write retires this cycle.
    always_comb begin
        pair_avail_s = 1'b0;
        wr_fire_s    = 1'b0;
        load_s       = 1'b0;
        pair_avail_s = !addr_empty_i && result_valid_i && !reset_cmd_i;
        wr_fire_s    = wr_valid_r && wb.wr_ready;
        // rst_n gating keeps the pop strobe low while reset is held.
        if (rst_n && pair_avail_s && ((state_r == S_IDLE) || wb.wr_ready)) begin
            load_s = 1'b1;
        end else begin
            load_s = 1'b0;
        end
    end

    // Writer FSM with registered write channel, done pulse and completion counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= S_IDLE;
            wr_valid_r <= 1'b0;
            waddr_r    <= {OPERAND_ADDR_WIDTH{1'b0}};
            wdata_r    <= {DATA_WIDTH{1'b0}};
            done_r     <= 1'b0;
            wb_cnt_r   <= {CNT_WIDTH{1'b0}};
        end else begin
            // A write handshaking alongside an abort still counts as done.
            done_r <= wr_fire_s;

            if (reset_cmd_i) begin
                wb_cnt_r <= {CNT_WIDTH{1'b0}};
            end else if (wr_fire_s) begin
                wb_cnt_r <= wb_cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end else begin
                wb_cnt_r <= wb_cnt_r;
            end

            case (state_r)
                S_IDLE: begin
                    if (load_s) begin
                        state_r    <= S_WRITE;
                        wr_valid_r <= 1'b1;
                        waddr_r    <= addr_rdata_i;
                        wdata_r    <= result_i;
                    end else begin
                        state_r    <= S_IDLE;
                        wr_valid_r <= 1'b0;
                    end
                end
                S_WRITE: begin
                    if (reset_cmd_i) begin
                        state_r    <= S_IDLE;
                        wr_valid_r <= 1'b0;
                    end else if (load_s) begin
                        // Back-to-back: retire current write and present the next one.
                        state_r    <= S_WRITE;
                        wr_valid_r <= 1'b1;
                        waddr_r    <= addr_rdata_i;
                        wdata_r    <= result_i;
                    end else if (wr_fire_s) begin
                        state_r    <= S_IDLE;
                        wr_valid_r <= 1'b0;
                    end else begin
                        state_r    <= S_WRITE;
                        wr_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r    <= S_IDLE;
                    wr_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign addr_rden_o    = load_s;
    assign result_ready_o = load_s;
    assign wb.wr_valid    = wr_valid_r;
    assign wb.waddr       = waddr_r;
    assign wb.wdata       = wdata_r;
    assign done_o         = done_r;
    assign wb_cnt_o       = wb_cnt_r;

endmodule

// File: tb/tb_vpu_wb_writer.sv
module tb_vpu_wb_writer;

    logic        clk;
    logic        rst_n;
    logic        reset_cmd_i;
    logic        addr_empty_i;
    logic [7:0]  addr_rdata_i;
    logic        addr_rden_o;
    logic        result_valid_i;
    logic [15:0] result_i;
    logic        result_ready_o;
    logic        done_o;
    logic [7:0]  wb_cnt_o;

    vpu_wb_writer_if #(.OPERAND_ADDR_WIDTH(8), .DATA_WIDTH(16)) wb_if ();

    vpu_wb_writer #(.OPERAND_ADDR_WIDTH(8), .DATA_WIDTH(16), .CNT_WIDTH(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .reset_cmd_i    (reset_cmd_i),
        .addr_empty_i   (addr_empty_i),
        .addr_rdata_i   (addr_rdata_i),
        .addr_rden_o    (addr_rden_o),
        .result_valid_i (result_valid_i),
        .result_i       (result_i),
        .result_ready_o (result_ready_o),
        .wb             (wb_if.master),
        .done_o         (done_o),
        .wb_cnt_o       (wb_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bench-side FIFO/result models and write scoreboard.
    logic [7:0]  addr_q[$];
    logic [15:0] res_q[$];
    logic [23:0] exp_q[$];
    logic [7:0]  cnt_m;
    logic        res_en;
    logic        s_rden;
    logic        s_rdy;
    int          total_cnt;
    int          pass_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total_cnt++;
        assert (obs === expv) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    task automatic drive();
        addr_empty_i   = (addr_q.size() == 0);
        addr_rdata_i   = (addr_q.size() != 0) ? addr_q[0] : 8'h00;
        result_valid_i = res_en && (res_q.size() != 0);
        result_i       = (res_q.size() != 0) ? res_q[0] : 16'h0000;
    endtask

    task automatic push_pair(input logic [7:0] a, input logic [15:0] d);
        addr_q.push_back(a);
        res_q.push_back(d);
        exp_q.push_back({a, d});
    endtask

    // One clock: sample at negedge, score writes, check registered outputs after the edge.
    task automatic tick();
        logic        fire;
        logic [23:0] e;
        @(negedge clk);
        s_rden = addr_rden_o;
        s_rdy  = result_ready_o;
        chk("rden_eq_ready", {31'd0, s_rden}, {31'd0, s_rdy});
        if (addr_empty_i) chk("no_pop_when_empty", {31'd0, s_rden}, 32'd0);
        fire = wb_if.wr_valid && wb_if.wr_ready;
        if (fire) begin
            chk("sb_has_entry", {31'd0, (exp_q.size() != 0)}, 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("sb_write", {8'd0, wb_if.waddr, wb_if.wdata}, {8'd0, e});
            end
            cnt_m = cnt_m + 8'd1;
        end
        if (reset_cmd_i) cnt_m = 8'd0;
        @(posedge clk);
        #1;
        chk("done", {31'd0, done_o}, {31'd0, fire});
        chk("wb_cnt", {24'd0, wb_cnt_o}, {24'd0, cnt_m});
        if (s_rden) begin
            if (addr_q.size() != 0) void'(addr_q.pop_front());
            if (res_q.size() != 0) void'(res_q.pop_front());
        end
        drive();
        #1;
    endtask

    initial begin
        logic [7:0] c0;
        total_cnt = 0;
        pass_cnt  = 0;
        cnt_m     = 8'd0;
        res_en    = 1'b1;
        rst_n     = 1'b0;
        reset_cmd_i = 1'b0;
        wb_if.wr_ready = 1'b1;
        push_pair(8'h12, 16'hABCD);
        drive();
        repeat (2) @(posedge clk);
        #1;
        // Reset state: outputs zero, no pop although a pair is presented.
        chk("rst_wr_valid", {31'd0, wb_if.wr_valid}, 32'd0);
        chk("rst_waddr", {24'd0, wb_if.waddr}, 32'd0);
        chk("rst_wdata", {16'd0, wb_if.wdata}, 32'd0);
        chk("rst_done", {31'd0, done_o}, 32'd0);
        chk("rst_cnt", {24'd0, wb_cnt_o}, 32'd0);
        chk("rst_rden", {31'd0, addr_rden_o}, 32'd0);
        chk("rst_ready", {31'd0, result_ready_o}, 32'd0);
        rst_n = 1'b1;

        // Single write.
        tick();
        chk("single_rden", {31'd0, s_rden}, 32'd1);
        chk("single_wr_valid", {31'd0, wb_if.wr_valid}, 32'd1);
        chk("single_waddr", {24'd0, wb_if.waddr}, 32'h12);
        chk("single_wdata", {16'd0, wb_if.wdata}, 32'hABCD);
        tick();
        chk("single_cnt", {24'd0, wb_cnt_o}, 32'd1);
        chk("single_idle", {31'd0, wb_if.wr_valid}, 32'd0);

        // Backpressure: hold for 5 cycles, second pair waits.
        wb_if.wr_ready = 1'b0;
        push_pair(8'h21, 16'h1111);
        push_pair(8'h22, 16'h2222);
        drive();
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_wr_valid", {31'd0, wb_if.wr_valid}, 32'd1);
            chk("bp_waddr", {24'd0, wb_if.waddr}, 32'h21);
            chk("bp_wdata", {16'd0, wb_if.wdata}, 32'h1111);
            chk("bp_no_pop", {31'd0, s_rden}, 32'd0);
        end
        wb_if.wr_ready = 1'b1;
        tick();
        chk("bp_second_pop", {31'd0, s_rden}, 32'd1);
        chk("bp_second_valid", {31'd0, wb_if.wr_valid}, 32'd1);
        chk("bp_second_waddr", {24'd0, wb_if.waddr}, 32'h22);
        tick();
        chk("bp_idle", {31'd0, wb_if.wr_valid}, 32'd0);
        chk("bp_cnt", {24'd0, wb_cnt_o}, 32'd3);

        // Streaming: clear count, then 4 back-to-back writes.
        reset_cmd_i = 1'b1;
        tick();
        reset_cmd_i = 1'b0;
        push_pair(8'h31, 16'h0001);
        push_pair(8'h32, 16'h0002);
        push_pair(8'h33, 16'h0003);
        push_pair(8'h34, 16'h0004);
        drive();
        tick();
        chk("stream_valid0", {31'd0, wb_if.wr_valid}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stream_no_bubble", {31'd0, wb_if.wr_valid}, 32'd1);
        end
        tick();
        chk("stream_idle", {31'd0, wb_if.wr_valid}, 32'd0);
        chk("stream_cnt", {24'd0, wb_cnt_o}, 32'd4);

        // Empty address FIFO: result waits, write follows one cycle after address appears.
        res_q.push_back(16'h5A5A);
        exp_q.push_back({8'h44, 16'h5A5A});
        drive();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("empty_ready", {31'd0, s_rdy}, 32'd0);
            chk("empty_no_write", {31'd0, wb_if.wr_valid}, 32'd0);
        end
        addr_q.push_back(8'h44);
        drive();
        tick();
        chk("empty_pop", {31'd0, s_rden}, 32'd1);
        chk("empty_valid", {31'd0, wb_if.wr_valid}, 32'd1);
        chk("empty_waddr", {24'd0, wb_if.waddr}, 32'h44);
        chk("empty_wdata", {16'd0, wb_if.wdata}, 32'h5A5A);
        tick();
        chk("empty_cnt", {24'd0, wb_cnt_o}, 32'd5);

        // Abort while stalled: no done, count cleared, idle next cycle.
        wb_if.wr_ready = 1'b0;
        push_pair(8'h55, 16'h7777);
        drive();
        tick();
        reset_cmd_i = 1'b1;
        tick();
        reset_cmd_i = 1'b0;
        void'(exp_q.pop_front());
        chk("abort_valid", {31'd0, wb_if.wr_valid}, 32'd0);
        chk("abort_cnt", {24'd0, wb_cnt_o}, 32'd0);

        // Abort during a handshake: write completes, count clears, no pop.
        push_pair(8'h77, 16'h0F0F);
        drive();
        tick();
        wb_if.wr_ready = 1'b1;
        reset_cmd_i = 1'b1;
        push_pair(8'h78, 16'hF0F0);
        drive();
        tick();
        reset_cmd_i = 1'b0;
        chk("abort_hs_no_pop", {31'd0, s_rden}, 32'd0);
        chk("abort_hs_valid", {31'd0, wb_if.wr_valid}, 32'd0);
        tick();
        chk("abort_hs_reload", {24'd0, wb_if.waddr}, 32'h78);
        tick();
        chk("abort_hs_cnt", {24'd0, wb_cnt_o}, 32'd1);

        // Counter wrap: 260 streamed writes.
        c0 = cnt_m;
        for (int i = 0; i < 260; i++) push_pair(8'(i), 16'(i) ^ 16'h3C3C);
        drive();
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) tick();
        chk("wrap_drained", exp_q.size(), 32'd0);
        chk("wrap_cnt", {24'd0, wb_cnt_o}, {24'd0, c0 + 8'd4});

        // Asynchronous reset mid-write.
        wb_if.wr_ready = 1'b0;
        push_pair(8'h99, 16'hBEEF);
        drive();
        tick();
        wb_if.wr_ready = 1'b1;
        push_pair(8'h9A, 16'hCAFE);
        drive();
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_wr_valid", {31'd0, wb_if.wr_valid}, 32'd0);
        chk("arst_waddr", {24'd0, wb_if.waddr}, 32'd0);
        chk("arst_wdata", {16'd0, wb_if.wdata}, 32'd0);
        chk("arst_done", {31'd0, done_o}, 32'd0);
        chk("arst_cnt", {24'd0, wb_cnt_o}, 32'd0);
        chk("arst_rden", {31'd0, addr_rden_o}, 32'd0);
        chk("arst_ready", {31'd0, result_ready_o}, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
